clk_monitor: RTL and testbench

Measures the period of a slow, asynchronous periodic signal (e.g. LFOSC 10 kHz output or a PLL-derived divided clock) in cycles of the system clock. Averages 2^AVG_LOG2 periods, reports the result, and flags in-range, lock and timeout. Sits beside the oscillator/PLL instances in top-level designs so firmware or LED logic can confirm a clock source is alive and on frequency.

---
 rtl/clk_monitor.sv | 160 ++++++++++++++++
 tb/tb_clk_monitor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Period monitor for a slow asynchronous clock: counts system clock cycles between
// rising edges, averages 2^AVG_LOG2 periods and flags in-range, lock and timeout.
module clk_monitor #(
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 2,
    parameter int MIN_CYC     = 4560,
    parameter int MAX_CYC     = 5040,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             lock,
    output logic             timeout,
    output logic [1:0]       dbg_state
);

    localparam int               ACC_W     = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    state_e              state_q;
    logic                s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    period_q;
    logic [ACC_W-1:0]    acc_q;
    logic [AVG_LOG2-1:0] smp_q;
    logic                valid_q;
    logic                in_range_q;
    logic                lock_q;
    logic                timeout_q;
    logic                prev_ok_q;

    logic                edge_d;
    logic                at_limit_d;
    logic                last_smp_d;
    logic                ok_d;
    logic [CNT_W-1:0]    cnt_inc_d;
    logic [ACC_W-1:0]    sum_d;
    logic [CNT_W-1:0]    avg_d;

    // s1/s2 resynchronise sig_in; s3 holds the previous synchronised value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        edge_d     = s2_q & ~s3_q;
        at_limit_d = (cnt_q == TIMEOUT_V);
        cnt_inc_d  = cnt_q + CNT_W'(1);
        sum_d      = acc_q + ACC_W'(cnt_q);
        avg_d      = CNT_W'(sum_d >> AVG_LOG2);
        ok_d       = (avg_d >= MIN_V) && (avg_d <= MAX_V);
        last_smp_d = &smp_q;
    end

    // period_valid is a single-cycle strobe, qualified with the period/in_range/lock values of that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            smp_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            lock_q     <= 1'b0;
            timeout_q  <= 1'b0;
            prev_ok_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!enable) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                acc_q      <= '0;
                smp_q      <= '0;
                in_range_q <= 1'b0;
                lock_q     <= 1'b0;
                timeout_q  <= 1'b0;
                prev_ok_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (edge_d) begin
                            cnt_q     <= CNT_W'(1);
                            timeout_q <= 1'b0;
                            state_q   <= ST_MEASURE;
                        end else if (at_limit_d) begin
                            timeout_q <= 1'b1;
                            lock_q    <= 1'b0;
                            prev_ok_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    ST_MEASURE: begin
                        // An edge on the limit cycle still counts as a sample; it outranks the timeout.
                        if (edge_d) begin
                            cnt_q <= CNT_W'(1);
                            if (last_smp_d) begin
                                period_q   <= avg_d;
                                valid_q    <= 1'b1;
                                in_range_q <= ok_d;
                                lock_q     <= ok_d & prev_ok_q;
                                prev_ok_q  <= ok_d;
                                acc_q      <= '0;
                                smp_q      <= '0;
                            end else begin
                                acc_q <= sum_d;
                                smp_q <= smp_q + AVG_LOG2'(1);
                            end
                        end else if (at_limit_d) begin
                            timeout_q <= 1'b1;
                            lock_q    <= 1'b0;
                            prev_ok_q <= 1'b0;
                            acc_q     <= '0;
                            smp_q     <= '0;
                            state_q   <= ST_ARM;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign in_range     = in_range_q;
    assign lock         = lock_q;
    assign timeout      = timeout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: randomized and directed square waves checked against an
// edge-time based reference model with an expected-result queue.
module tb_clk_monitor;

    localparam int CNT_W       = 12;
    localparam int AVG_LOG2    = 2;
    localparam int MIN_CYC     = 114;
    localparam int MAX_CYC     = 126;
    localparam int TIMEOUT_CYC = 256;
    localparam int NAVG        = 1 << AVG_LOG2;
    localparam int NOM         = 120;
    localparam int EW          = 50;

    // clock / reset
    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_range;
    logic             lock;
    logic             timeout;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    clk_monitor #(
        .CNT_W      (CNT_W),
        .AVG_LOG2   (AVG_LOG2),
        .MIN_CYC    (MIN_CYC),
        .MAX_CYC    (MAX_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .enable      (enable),
        .period      (period),
        .period_valid(period_valid),
        .in_range    (in_range),
        .lock        (lock),
        .timeout     (timeout),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // reference model: works on detection times of rising edges
    logic [EW-1:0] exp_q[$];
    int            smp_q[$];
    bit            m_armed;
    int            m_last_det;
    bit            m_prev_ok;
    bit            m_lock;
    bit            m_in_range;
    bit            m_timeout;
    int            m_period;

    function automatic void model_reset();
        m_armed    = 0;
        m_last_det = 0;
        m_prev_ok  = 0;
        m_lock     = 0;
        m_in_range = 0;
        m_timeout  = 0;
        m_period   = 0;
        smp_q.delete();
    endfunction

    function automatic void model_disable();
        m_armed    = 0;
        m_prev_ok  = 0;
        m_lock     = 0;
        m_in_range = 0;
        m_timeout  = 0;
        smp_q.delete();
    endfunction

    function automatic void model_timeout();
        m_armed   = 0;
        m_prev_ok = 0;
        m_lock    = 0;
        m_timeout = 1;
        smp_q.delete();
    endfunction

    function automatic void model_edge(input int det);
        int sum;
        int avg;
        bit ok;
        if (!m_armed) begin
            m_armed   = 1;
            m_timeout = 0;
        end else begin
            smp_q.push_back(det - m_last_det);
            if (smp_q.size() == NAVG) begin
                sum = 0;
                foreach (smp_q[i]) sum += smp_q[i];
                avg        = sum / NAVG;
                ok         = (avg >= MIN_CYC) && (avg <= MAX_CYC);
                m_lock     = ok && m_prev_ok;
                m_prev_ok  = ok;
                m_in_range = ok;
                m_period   = avg;
                exp_q.push_back({32'(det), m_lock, ok, 16'(avg)});
                smp_q.delete();
            end
        end
        m_last_det = det;
    endfunction

    // driver tasks
    task automatic pulse(input int p);
        @(negedge clk);
        sig_in = 1'b1;
        model_edge(cyc + 3);
        repeat (p / 2) @(negedge clk);
        sig_in = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clk);
    endtask

    task automatic run_group(input int a, input int b, input int c, input int d);
        while (!(m_armed && smp_q.size() == NAVG - 1)) pulse(NOM);
        pulse(a);
        pulse(b);
        pulse(c);
        pulse(d);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_period"}, 64'(period), 64'(m_period));
        chk({tag, "_in_range"}, 64'(in_range), 64'(m_in_range));
        chk({tag, "_lock"}, 64'(lock), 64'(m_lock));
        chk({tag, "_timeout"}, 64'(timeout), 64'(m_timeout));
    endtask

    // scoreboard monitor
    logic [EW-1:0] mon_e;
    int            to_rises    = 0;
    int            to_rise_cyc = 0;
    logic          to_prev     = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (period_valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("valid_cycle", 64'(cyc), 64'(mon_e[49:18]));
                    chk("valid_period", 64'(period), 64'(mon_e[15:0]));
                    chk("valid_in_range", 64'(in_range), 64'(mon_e[16]));
                    chk("valid_lock", 64'(lock), 64'(mon_e[17]));
                end
            end
            if (timeout && !to_prev) begin
                to_rises    <= to_rises + 1;
                to_rise_cyc <= cyc;
            end
            to_prev <= timeout;
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  exp_to;
        bit  seen;
        int  lo;
        int  hi;
        int  n;

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_period", 64'(period), 64'(0));
        chk("rst_valid", 64'(period_valid), 64'(0));
        chk("rst_in_range", 64'(in_range), 64'(0));
        chk("rst_lock", 64'(lock), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // nominal wave: first result unlocked, second locked
        repeat (9) pulse(NOM);
        chk("basic_period", 64'(period), 64'(120));
        chk("basic_in_range", 64'(in_range), 64'(1));
        chk("basic_lock", 64'(lock), 64'(1));

        // too-fast wave, then back to nominal
        run_group(100, 100, 100, 100);
        run_group(100, 100, 100, 100);
        pulse(NOM);
        chk("fast_period", 64'(period), 64'(100));
        chk("fast_in_range", 64'(in_range), 64'(0));
        chk("fast_lock", 64'(lock), 64'(0));
        run_group(NOM, NOM, NOM, NOM);
        run_group(NOM, NOM, NOM, NOM);
        pulse(NOM);
        chk("relock_period", 64'(period), 64'(120));
        chk("relock_lock", 64'(lock), 64'(1));

        // range boundaries, alternation and truncation
        run_group(114, 114, 114, 114);
        run_group(126, 126, 126, 126);
        chk("min_edge_in_range", 64'(in_range), 64'(1));
        run_group(113, 113, 113, 113);
        chk("max_edge_in_range", 64'(in_range), 64'(1));
        run_group(127, 127, 127, 127);
        chk("below_min_in_range", 64'(in_range), 64'(0));
        run_group(115, 125, 115, 125);
        chk("above_max_in_range", 64'(in_range), 64'(0));
        run_group(121, 121, 121, 122);
        chk("alt_period", 64'(period), 64'(120));
        pulse(NOM);
        chk("trunc_period", 64'(period), 64'(121));

        // random periods
        for (int r = 0; r < 4; r++) begin
            lo = int'($urandom_range(135, 100));
            hi = lo + int'($urandom_range(20, 0));
            n  = int'($urandom_range(12, 6));
            repeat (n) pulse(int'($urandom_range(hi, lo)));
        end

        // lock, then stop the wave until timeout
        run_group(NOM, NOM, NOM, NOM);
        run_group(NOM, NOM, NOM, NOM);
        pulse(NOM);
        chk("pre_timeout_lock", 64'(lock), 64'(1));
        exp_to = m_last_det + TIMEOUT_CYC;
        base   = to_rises;
        seen   = 0;
        for (int i = 0; i < 2 * TIMEOUT_CYC; i++) begin
            @(negedge clk);
            #1;
            if (to_rises != base) begin
                seen = 1;
                break;
            end
        end
        chk("timeout_seen", 64'(seen), 64'(1));
        chk("timeout_cycle", 64'(to_rise_cyc), 64'(exp_to));
        chk("timeout_lock", 64'(lock), 64'(0));
        chk("timeout_flag", 64'(timeout), 64'(1));
        model_timeout();
        repeat (20) @(negedge clk);
        chk("timeout_held", 64'(timeout), 64'(1));
        pulse(NOM);
        chk("timeout_cleared", 64'(timeout), 64'(0));
        repeat (8) pulse(NOM);
        check_status("restart");

        // edge exactly on the timeout limit is a valid sample
        base = to_rises;
        run_group(TIMEOUT_CYC, NOM, NOM, NOM);
        pulse(NOM);
        chk("limit_edge_no_timeout", 64'(to_rises), 64'(base));
        chk("limit_edge_timeout", 64'(timeout), 64'(0));
        chk("limit_edge_period", 64'(period), 64'(154));

        // drop enable mid-average
        while (!(m_armed && smp_q.size() == 2)) pulse(NOM);
        @(negedge clk);
        enable = 1'b0;
        model_disable();
        repeat (10) @(negedge clk);
        chk("idle_period_hold", 64'(period), 64'(154));
        chk("idle_lock", 64'(lock), 64'(0));
        chk("idle_in_range", 64'(in_range), 64'(0));
        chk("idle_state", 64'(dbg_state), 64'(0));
        enable = 1'b1;
        repeat (9) pulse(NOM);
        chk("reenable_period", 64'(period), 64'(120));
        chk("reenable_lock", 64'(lock), 64'(1));

        // asynchronous reset mid-measurement
        repeat (2) pulse(NOM);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_period", 64'(period), 64'(0));
        chk("async_rst_valid", 64'(period_valid), 64'(0));
        chk("async_rst_in_range", 64'(in_range), 64'(0));
        chk("async_rst_lock", 64'(lock), 64'(0));
        chk("async_rst_timeout", 64'(timeout), 64'(0));
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) pulse(NOM);
        check_status("post_reset");

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
